// File: rtl/dvf_rst_seq_pkg.sv
// Shared types and constants for the dvf_rst_seq reset sequencer.
package dvf_rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    STRETCH,
    RELEASE,
    DONE
  } rst_seq_state_e;

  localparam int SW_CNT_W = 8;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dvf_rst_sync2.sv
// Two-flop reset synchronizer: asserts asynchronously, deasserts on the second clk edge.
module dvf_rst_sync2 (
  input  logic clk,
  input  logic rst_n,
  output logic rst_n_sync
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta       <= 1'b0;
      rst_n_sync <= 1'b0;
    end else begin
      meta       <= 1'b1;
      rst_n_sync <= meta;
    end
  end

endmodule

// File: rtl/dvf_rst_seq.sv
// Reset sequencer: stretched, staggered release of NUM_OUT resets plus software restart.
// Optional clock enable with lead time when DVF_RST_SEQ_CLK_GATE_EN is defined.
module dvf_rst_seq
  import dvf_rst_seq_pkg::*;
#(
  parameter int NUM_OUT      = 3,
  parameter int STRETCH_CLKS = 16,
  parameter int STAGGER_CLKS = 4,
  parameter int CLK_LEAD     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sw_rst_req,
  output logic [NUM_OUT-1:0]  rst_n_out,
  output logic                rst_done,
  output logic                busy,
  output logic [SW_CNT_W-1:0] sw_rst_cnt
`ifdef DVF_RST_SEQ_CLK_GATE_EN
  ,
  output logic                clk_en
`endif
);

  localparam int CNT_W = $clog2(max2(STRETCH_CLKS, STAGGER_CLKS) + 1);

  if (NUM_OUT < 1 || NUM_OUT > 16) begin : g_bad_num_out
    $error("dvf_rst_seq: NUM_OUT must be in 1..16");
  end
  if (STRETCH_CLKS < 1) begin : g_bad_stretch
    $error("dvf_rst_seq: STRETCH_CLKS must be >= 1");
  end
  if (STAGGER_CLKS < 1) begin : g_bad_stagger
    $error("dvf_rst_seq: STAGGER_CLKS must be >= 1");
  end
  if (CLK_LEAD < 0) begin : g_bad_lead_neg
    $error("dvf_rst_seq: CLK_LEAD must be >= 0");
  end
`ifdef DVF_RST_SEQ_CLK_GATE_EN
  if (CLK_LEAD >= STRETCH_CLKS) begin : g_bad_lead
    $error("dvf_rst_seq: CLK_LEAD must be < STRETCH_CLKS");
  end
`endif

  rst_seq_state_e state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rst_n_sync;
  logic                stretching, stretch_end, stagger_end, sw_go;
  logic [NUM_OUT-1:0]  release_next;
  logic [NUM_OUT-1:0]  rst_n_out_d;
  logic                rst_done_d;
  logic [SW_CNT_W-1:0] sw_rst_cnt_d;
`ifdef DVF_RST_SEQ_CLK_GATE_EN
  logic                clk_en_d;
`endif

  dvf_rst_sync2 u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_n_sync (rst_n_sync)
  );

  // The edge that raises rst_n_sync is the STRETCH entry edge; ASSERT with the
  // synchronizer already high is therefore counted as the first STRETCH cycle.
  assign stretching   = (state_q == STRETCH) || ((state_q == ASSERT) && rst_n_sync);
  assign stretch_end  = stretching && (cnt_q == CNT_W'(STRETCH_CLKS - 1));
  assign stagger_end  = (state_q == RELEASE) && (cnt_q == CNT_W'(STAGGER_CLKS - 1));
  assign sw_go        = (state_q == DONE) && sw_rst_req;
  assign release_next = (rst_n_out << 1) | NUM_OUT'(1);
  assign busy         = ~rst_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stretching) begin
      if (stretch_end) begin
        state_d = (NUM_OUT == 1) ? DONE : RELEASE;
        cnt_d   = '0;
      end else begin
        state_d = STRETCH;
        cnt_d   = cnt_q + 1'b1;
      end
    end else if (state_q == RELEASE) begin
      if (stagger_end) begin
        cnt_d = '0;
        if (&release_next) state_d = DONE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (sw_go) begin
      state_d = STRETCH;
      cnt_d   = '0;
    end
  end

  always_comb begin
    rst_n_out_d  = rst_n_out;
    rst_done_d   = rst_done;
    sw_rst_cnt_d = sw_rst_cnt;
`ifdef DVF_RST_SEQ_CLK_GATE_EN
    clk_en_d     = clk_en;
`endif
    if (stretch_end) begin
      rst_n_out_d = NUM_OUT'(1);
      rst_done_d  = (NUM_OUT == 1);
    end else if (stagger_end) begin
      rst_n_out_d = release_next;
      rst_done_d  = &release_next;
    end else if (sw_go) begin
      rst_n_out_d  = '0;
      rst_done_d   = 1'b0;
      sw_rst_cnt_d = (sw_rst_cnt == '1) ? sw_rst_cnt : sw_rst_cnt + 1'b1;
`ifdef DVF_RST_SEQ_CLK_GATE_EN
      clk_en_d     = 1'b0;
`endif
    end
`ifdef DVF_RST_SEQ_CLK_GATE_EN
    if (stretching && (cnt_q == CNT_W'(STRETCH_CLKS - CLK_LEAD - 1))) clk_en_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_n_out  <= '0;
      rst_done   <= 1'b0;
      sw_rst_cnt <= '0;
`ifdef DVF_RST_SEQ_CLK_GATE_EN
      clk_en     <= 1'b0;
`endif
    end else begin
      rst_n_out  <= rst_n_out_d;
      rst_done   <= rst_done_d;
      sw_rst_cnt <= sw_rst_cnt_d;
`ifdef DVF_RST_SEQ_CLK_GATE_EN
      clk_en     <= clk_en_d;
`endif
    end
  end

endmodule

// File: tb/tb_dvf_rst_seq.sv
// Scoreboard bench for dvf_rst_seq: expected output events are queued from a timing model.
`timescale 1ns/1ps
module tb_dvf_rst_seq;

  localparam int N    = 3;
  localparam int ST   = 16;
  localparam int SG   = 4;
  localparam int LEAD = 4;
  localparam int BIG  = 1 << 30;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         sw_rst_req = 1'b0;
  logic         sw1 = 1'b0;
  logic [N-1:0] rst_n_out;
  logic         rst_done, busy;
  logic [7:0]   sw_rst_cnt;
  logic [0:0]   out1;
  logic         done1, busy1;
  logic [7:0]   cnt1;
`ifdef DVF_RST_SEQ_CLK_GATE_EN
  logic         clk_en, clk_en1;
`endif

  always #5 clk = ~clk;

  dvf_rst_seq #(.NUM_OUT(N), .STRETCH_CLKS(ST), .STAGGER_CLKS(SG), .CLK_LEAD(LEAD)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw_rst_req),
    .rst_n_out  (rst_n_out),
    .rst_done   (rst_done),
    .busy       (busy),
    .sw_rst_cnt (sw_rst_cnt)
`ifdef DVF_RST_SEQ_CLK_GATE_EN
    ,
    .clk_en     (clk_en)
`endif
  );

  dvf_rst_seq #(.NUM_OUT(1), .STRETCH_CLKS(1), .STAGGER_CLKS(1), .CLK_LEAD(0)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst_req (sw1),
    .rst_n_out  (out1),
    .rst_done   (done1),
    .busy       (busy1),
    .sw_rst_cnt (cnt1)
`ifdef DVF_RST_SEQ_CLK_GATE_EN
    ,
    .clk_en     (clk_en1)
`endif
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] outv;
    logic         done;
    int           cnt;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  done_edge = BIG;
  int  model_cnt = 0;
  int  en_on = BIG;
  int  rel = 0;
  int  d1_rise = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every change on rst_n_out/rst_done consumes one expected event.
  logic [N-1:0] prev_out = '0;
  logic         prev_done = 1'b0;
  logic         d1_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && (rst_n_out !== prev_out || rst_done !== prev_done)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change: got out=%b done=%b with no event pending (cycle %0d)",
                 rst_n_out, rst_done, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("event_cycle", cyc, e.cyc);
        chk("rst_n_out", int'(rst_n_out), int'(e.outv));
        chk("rst_done", int'(rst_done), int'(e.done));
        chk("busy", int'(busy), int'(!e.done));
        chk("sw_rst_cnt", int'(sw_rst_cnt), e.cnt);
      end
    end
    prev_out  = rst_n_out;
    prev_done = rst_done;
`ifdef DVF_RST_SEQ_CLK_GATE_EN
    chk("clk_en", int'(clk_en), int'(rst_n && cyc >= en_on));
`endif
    if (rst_n && done1 && !d1_prev) d1_rise = cyc;
    d1_prev = done1;
  end

  function automatic void push_seq(input int start, input bit from_sw);
    if (from_sw) q.push_back('{start, '0, 1'b0, model_cnt});
    for (int i = 0; i < N; i++)
      q.push_back('{start + ST + i * SG, N'((1 << (i + 1)) - 1), (i == N - 1), model_cnt});
    done_edge = start + ST + (N - 1) * SG;
    en_on     = start + ST - LEAD;
  endfunction

  // Called at negedge+1: drives sw for the coming edge and models acceptance.
  task automatic step(input logic sw);
    sw_rst_req = sw;
    if (sw && rst_n && (cyc + 1) > done_edge) begin
      model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
      push_seq(cyc + 1, 1'b1);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    done_edge = BIG;
    en_on     = BIG;
    model_cnt = 0;
    d1_rise   = -1;
    #1;
    chk("async_rst_n_out", int'(rst_n_out), 0);
    chk("async_rst_done", int'(rst_done), 0);
    chk("async_busy", int'(busy), 1);
    chk("async_sw_rst_cnt", int'(sw_rst_cnt), 0);
    chk("async_out1", int'(out1), 0);
`ifdef DVF_RST_SEQ_CLK_GATE_EN
    chk("async_clk_en", int'(clk_en), 0);
`endif
    @(negedge clk);
    #1;
  endtask

  task automatic do_release();
    rst_n = 1'b1;
    rel   = cyc;
    push_seq(cyc + 2, 1'b0);
    step(1'b0);
  endtask

  task automatic run_to_done();
    int budget = 200;
    while (cyc <= done_edge + 1 && budget > 0) begin
      step(1'b0);
      budget--;
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("por_rst_n_out", int'(rst_n_out), 0);
    chk("por_rst_done", int'(rst_done), 0);
    chk("por_busy", int'(busy), 1);
    chk("por_sw_rst_cnt", int'(sw_rst_cnt), 0);
    @(negedge clk);
    #1;
    repeat (2) step(1'b0);

    // Power-on sequence, including the minimal single-output instance
    do_release();
    run_to_done();
    chk("dut1_rise_e3", d1_rise, rel + 3);
    chk("dut1_out", int'(out1), 1);

    // Reset collapses a sequence mid-RELEASE, then a clean re-release
    do_reset();
    repeat (2) step(1'b0);
    do_release();
    while (cyc < rel + 20) step(1'b0);
    do_reset();
    step(1'b0);
    do_release();
    run_to_done();
    chk("dut1_rise_rerelease", d1_rise, rel + 3);

    // Software restart, then random requests mostly landing mid-sequence
    step(1'b1);
    for (int k = 0; k < 60; k++) step(logic'($urandom_range(0, 3) == 0));
    run_to_done();
    chk("sw_cnt_after_random", int'(sw_rst_cnt), model_cnt);

    // Request held high retriggers at each DONE entry
    repeat (80) step(1'b1);
    step(1'b0);
    run_to_done();
    chk("sw_cnt_after_hold", int'(sw_rst_cnt), model_cnt);

    // Saturation: 300 accepted requests
    for (int p = 0; p < 300; p++) begin
      int gap;
      while (cyc + 1 <= done_edge) step(1'b0);
      gap = $urandom_range(0, 3);
      repeat (gap) step(1'b0);
      step(1'b1);
    end
    step(1'b0);
    run_to_done();
    chk("sw_cnt_saturated", int'(sw_rst_cnt), 255);
    chk("events_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
